// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting one UART transmitter to NUM_REQ packet sources; grant one cycle after request.
// Owner's valid/data pass straight through, tx_ready backpressures only the owner; idle owners are evicted after IDLE_TIMEOUT.
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           timeout_pulse
);

  localparam int          IDX_W   = $clog2(NUM_REQ);
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_OWN  = 1'b1;
  localparam logic [15:0] TO_LAST = 16'(IDLE_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;

  logic             own, own_vld, own_last, xfer, expire;
  logic [IDX_W-1:0] winner, cand_idx;
  logic             found;
  int               cand;

  // owner_q doubles as last_owner: it is loaded at grant time and kept after release
  assign own      = (state_q == ST_OWN);
  assign own_vld  = req_valid[owner_q];
  assign own_last = req_last[owner_q];
  assign xfer     = own & own_vld & tx_ready;
  assign expire   = own & ~own_vld & (idle_cnt_q == TO_LAST);

  assign busy          = own;
  assign tx_valid      = own & own_vld;
  assign tx_data       = own ? req_data[owner_q*DATA_BITS +: DATA_BITS] : '0;
  assign req_ready     = grant & {NUM_REQ{tx_ready}};
  assign timeout_pulse = expire;

  always_comb begin
    grant = '0;
    if (own) grant[owner_q] = 1'b1;
  end

  // search begins one past the previous owner so every requester gets a turn
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(owner_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (|req_valid) begin
          state_d = ST_OWN;
          owner_d = winner;
        end
      end
      ST_OWN: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (own_last) state_d = ST_IDLE;
        end else if (!own_vld) begin
          // stalled-by-transmitter cycles fall through here untouched
          if (expire) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
          end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= IDX_W'(NUM_REQ - 1);
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-cycle vector table plus hand sequences for backpressure, timeout and async reset.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DB-1:0] req_data;
  logic            tx_valid, tx_ready, busy, timeout_pulse;
  logic [DB-1:0]   tx_data;

  uart_tx_arb #(.NUM_REQ(N), .DATA_BITS(DB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic [31:0] dat;
    logic [3:0]  lst;
    logic        txr;
    logic [3:0]  e_gnt;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic        e_to;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [31:0] d, logic [3:0] l, logic t,
                              logic [3:0] g, logic v, logic [7:0] x, logic [3:0] y, logic b, logic o);
    vec_t e;
    e.rst_n = r; e.rv = rv; e.dat = d; e.lst = l; e.txr = t;
    e.e_gnt = g; e.e_txv = v; e.e_txd = x; e.e_rdy = y; e.e_busy = b; e.e_to = o;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_reset();
    reset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  // every accepted byte must match the oldest byte the stimulus expected to be sent
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_extra: got byte %0h, expected no transfer", tx_data);
      end else begin
        chk("sb_byte", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d4;
    d4 = 32'hD3C2B1A0;
    reset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    next_cycle();

    // single requester packet, then all four requesters rotating
    vt.push_back(mk(0, 4'b0000, 32'h0,  4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0000, 32'h0,  4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0001, 32'h11, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0001, 32'h11, 4'b0000, 1, 4'b0001, 1, 8'h11, 4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b0001, 32'h22, 4'b0000, 1, 4'b0001, 1, 8'h22, 4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b0001, 32'h33, 4'b0001, 1, 4'b0001, 1, 8'h33, 4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b0000, 32'h0,  4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(0, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0001, 1, 8'hA0, 4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0010, 1, 8'hB1, 4'b0010, 1, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0100, 1, 8'hC2, 4'b0100, 1, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b1000, 1, 8'hD3, 4'b1000, 1, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, d4,     4'b1111, 1, 4'b0001, 1, 8'hA0, 4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b0000, d4,     4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0));

    foreach (vt[k]) begin
      reset = vt[k].rst_n; req_valid = vt[k].rv; req_data = vt[k].dat;
      req_last = vt[k].lst; tx_ready = vt[k].txr;
      if (vt[k].e_txv && vt[k].txr) sb_q.push_back(vt[k].e_txd);
      @(negedge clk);
      chk($sformatf("v%0d_grant", k), {28'h0, grant}, {28'h0, vt[k].e_gnt});
      chk($sformatf("v%0d_txv", k), {31'h0, tx_valid}, {31'h0, vt[k].e_txv});
      chk($sformatf("v%0d_txd", k), {24'h0, tx_data}, {24'h0, vt[k].e_txd});
      chk($sformatf("v%0d_rdy", k), {28'h0, req_ready}, {28'h0, vt[k].e_rdy});
      chk($sformatf("v%0d_busy", k), {31'h0, busy}, {31'h0, vt[k].e_busy});
      chk($sformatf("v%0d_to", k), {31'h0, timeout_pulse}, {31'h0, vt[k].e_to});
      next_cycle();
    end

    // transmitter stall much longer than the idle timeout
    hs_reset();
    req_valid = 4'b0100; req_data = 32'h005A0000; req_last = 4'b0100; tx_ready = 1'b0;
    @(negedge clk); chk("bp_idle_grant", {28'h0, grant}, 32'h0);
    next_cycle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_grant", {28'h0, grant}, 32'h4);
      chk("bp_data", {24'h0, tx_data}, 32'h5A);
      chk("bp_rdy", {28'h0, req_ready}, 32'h0);
      chk("bp_to", {31'h0, timeout_pulse}, 32'h0);
      next_cycle();
    end
    tx_ready = 1'b1; sb_q.push_back(8'h5A);
    @(negedge clk); chk("bp_rdy_release", {28'h0, req_ready}, 32'h4);
    next_cycle();
    req_valid = '0;
    @(negedge clk); chk("bp_done_grant", {28'h0, grant}, 32'h0);
    next_cycle();

    // owner goes quiet after a non-last byte
    hs_reset();
    req_valid = 4'b0010; req_data = 32'h00007700; req_last = 4'b0000; tx_ready = 1'b1;
    @(negedge clk); chk("to_idle_grant", {28'h0, grant}, 32'h0);
    next_cycle();
    sb_q.push_back(8'h77);
    @(negedge clk); chk("to_own_grant", {28'h0, grant}, 32'h2);
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("to_pulse_c%0d", k), {31'h0, timeout_pulse}, (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("to_grant_c%0d", k), {28'h0, grant}, (k <= 8) ? 32'h2 : 32'h0);
      next_cycle();
    end

    // competing requester is held off until the owner's packet ends
    hs_reset();
    req_valid = 4'b1001; req_data = 32'hEE000000; req_last = 4'b1000; tx_ready = 1'b1;
    @(negedge clk); chk("ni_idle_grant", {28'h0, grant}, 32'h0);
    next_cycle();
    for (int b = 1; b <= 3; b++) begin
      req_data[7:0] = 8'(b); req_last[0] = (b == 3);
      sb_q.push_back(8'(b));
      @(negedge clk);
      chk("ni_rdy_owner_only", {28'h0, req_ready}, 32'h1);
      chk("ni_grant0", {28'h0, grant}, 32'h1);
      next_cycle();
    end
    @(negedge clk);
    chk("ni_gap_grant", {28'h0, grant}, 32'h0);
    chk("ni_gap_rdy", {28'h0, req_ready}, 32'h0);
    next_cycle();
    sb_q.push_back(8'hEE);
    @(negedge clk);
    chk("ni_grant3", {28'h0, grant}, 32'h8);
    chk("ni_rdy3", {28'h0, req_ready}, 32'h8);
    next_cycle();
    req_valid = '0;
    @(negedge clk); chk("ni_end_grant", {28'h0, grant}, 32'h0);
    next_cycle();

    // asynchronous reset in the middle of a packet
    hs_reset();
    req_valid = 4'b0100; req_data = 32'h00990000; req_last = 4'b0000; tx_ready = 1'b1;
    @(negedge clk); chk("ar_idle_grant", {28'h0, grant}, 32'h0);
    next_cycle();
    sb_q.push_back(8'h99);
    @(negedge clk); chk("ar_own_grant", {28'h0, grant}, 32'h4);
    next_cycle();
    #1; chk("ar_pre_busy", {31'h0, busy}, 32'h1);
    chk("ar_pre_rdy", {28'h0, req_ready}, 32'h4);
    #1; reset = 1'b0;
    #1;
    chk("ar_grant", {28'h0, grant}, 32'h0);
    chk("ar_busy", {31'h0, busy}, 32'h0);
    chk("ar_txv", {31'h0, tx_valid}, 32'h0);
    chk("ar_txd", {24'h0, tx_data}, 32'h0);
    chk("ar_rdy", {28'h0, req_ready}, 32'h0);
    chk("ar_to", {31'h0, timeout_pulse}, 32'h0);
    next_cycle();
    reset = 1'b1;
    req_valid = 4'b1101; req_data = 32'h33994442; req_last = 4'b1101; tx_ready = 1'b1;
    @(negedge clk); chk("ar_rel_grant", {28'h0, grant}, 32'h0);
    next_cycle();
    sb_q.push_back(8'h42);
    @(negedge clk);
    chk("ar_first_winner", {28'h0, grant}, 32'h1);
    chk("ar_first_data", {24'h0, tx_data}, 32'h42);
    next_cycle();
    req_valid = '0;
    @(negedge clk); chk("ar_end_grant", {28'h0, grant}, 32'h0);
    next_cycle();

    chk("sb_leftover", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
